// File: rtl/rab_pkg.sv
// Shared types for the RAB lookup front-end.
// Fault causes, FSM states and AXI burst encodings.
package rab_pkg;

  typedef enum logic [1:0] {
    CAUSE_MISS  = 2'b00,
    CAUSE_PROT  = 2'b01,
    CAUSE_MULTI = 2'b10,
    CAUSE_WRAP  = 2'b11
  } cause_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_LOOKUP = 2'b01,
    ST_RESP   = 2'b10
  } state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

endpackage

// File: rtl/rab_miss_fifo.sv
// Synchronous FIFO holding translation-fault records.
// A pop in the same cycle frees a slot for a push when full.
module rab_miss_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_q;
  logic [AW:0]      rd_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_en;
  logic             push_en;

  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) &&
                 (wr_q[AW-1:0] == rd_q[AW-1:0]);

  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign rdata   = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_en) begin
        mem_q[wr_q[AW-1:0]] <= wdata;
        wr_q <= wr_q + ONE;
      end
      if (pop_en) begin
        rd_q <= rd_q + ONE;
      end
    end
  end

endmodule

// File: rtl/rab_lookup_ctrl.sv
// RAB lookup front-end: burst window, slice lookup, result routing.
// Faults go to the error port and are logged in the miss FIFO.
module rab_lookup_ctrl
  import rab_pkg::*;
#(
  parameter int N_SLICES        = 16,
  parameter int ADDR_WIDTH_VIRT = 32,
  parameter int ADDR_WIDTH_PHYS = 40,
  parameter int ID_WIDTH        = 8,
  parameter int MISS_FIFO_DEPTH = 4
) (
  input  logic                       Clk_CI,
  input  logic                       Rst_RBI,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [ADDR_WIDTH_VIRT-1:0] req_addr_i,
  input  logic [7:0]                 req_len_i,
  input  logic [2:0]                 req_size_i,
  input  logic [1:0]                 req_burst_i,
  input  logic [ID_WIDTH-1:0]        req_id_i,
  input  logic                       req_rw_i,
  output logic                       lookup_rw_o,
  output logic [ADDR_WIDTH_VIRT-1:0] lookup_addr_min_o,
  output logic [ADDR_WIDTH_VIRT-1:0] lookup_addr_max_o,
  input  logic [N_SLICES-1:0]        lookup_hit_i,
  input  logic [N_SLICES-1:0]        lookup_prot_i,
  input  logic                       lookup_multi_hit_i,
  input  logic [ADDR_WIDTH_PHYS-1:0] lookup_out_addr_i,
  input  logic                       lookup_coherent_i,
  output logic                       fwd_valid_o,
  input  logic                       fwd_ready_i,
  output logic [ADDR_WIDTH_PHYS-1:0] fwd_addr_o,
  output logic [ID_WIDTH-1:0]        fwd_id_o,
  output logic                       fwd_coherent_o,
  output logic                       err_valid_o,
  input  logic                       err_ready_i,
  output logic [ID_WIDTH-1:0]        err_id_o,
  output logic [1:0]                 err_cause_o,
  output logic                       miss_valid_o,
  input  logic                       miss_ready_i,
  output logic [ADDR_WIDTH_VIRT-1:0] miss_addr_o,
  output logic [ID_WIDTH-1:0]        miss_id_o,
  output logic                       miss_rw_o,
  output logic                       miss_overflow_o,
  input  logic                       miss_overflow_clr_i
);

  localparam int AV = ADDR_WIDTH_VIRT;
  localparam int AP = ADDR_WIDTH_PHYS;
  localparam int SW = AV + 1;
  localparam int EW = AV + ID_WIDTH + 1;

  state_e              state_q;
  state_e              state_d;
  logic                accept;
  logic                capture;
  logic                done;

  logic [SW-1:0]       bytes;
  logic [SW-1:0]       base;
  logic [SW-1:0]       sum;

  logic [AV-1:0]       addr_min_q;
  logic [AV-1:0]       addr_max_q;
  logic                wrap_q;
  logic [ID_WIDTH-1:0] id_q;
  logic                rw_q;

  logic                fwd_valid_q;
  logic [AP-1:0]       fwd_addr_q;
  logic [ID_WIDTH-1:0] fwd_id_q;
  logic                fwd_coh_q;
  logic                err_valid_q;
  logic [ID_WIDTH-1:0] err_id_q;
  cause_e              err_cause_q;
  logic                ovf_q;

  cause_e              cause;
  logic                fwd_hit;
  logic                push;
  logic                pop;
  logic                fifo_full;
  logic                fifo_empty;
  logic                ovf_set;
  logic [EW-1:0]       fifo_rdata;

  // Carry out of the (AV+1)-bit sum flags a window crossing the top
  always_comb begin
    bytes = '0;
    if (req_burst_i == BURST_FIXED) begin
      bytes = SW'(1) << req_size_i;
    end else begin
      bytes = SW'({1'b0, req_len_i} + 9'd1) << req_size_i;
    end
    base = {1'b0, req_addr_i};
    if (req_burst_i == BURST_WRAP) begin
      base = base & ~(bytes - SW'(1));
    end
    sum = base + bytes - SW'(1);
  end

  always_comb begin
    cause   = CAUSE_MISS;
    fwd_hit = 1'b0;
    priority case (1'b1)
      wrap_q:             cause   = CAUSE_WRAP;
      lookup_multi_hit_i: cause   = CAUSE_MULTI;
      |lookup_hit_i:      fwd_hit = 1'b1;
      |lookup_prot_i:     cause   = CAUSE_PROT;
      default:            cause   = CAUSE_MISS;
    endcase
  end

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_d = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        capture = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if ((fwd_valid_q && fwd_ready_i) ||
            (err_valid_q && err_ready_i)) begin
          done    = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign req_ready_o = Rst_RBI && (state_q == ST_IDLE);

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      addr_min_q  <= '0;
      addr_max_q  <= '0;
      wrap_q      <= 1'b0;
      id_q        <= '0;
      rw_q        <= 1'b0;
      fwd_valid_q <= 1'b0;
      fwd_addr_q  <= '0;
      fwd_id_q    <= '0;
      fwd_coh_q   <= 1'b0;
      err_valid_q <= 1'b0;
      err_id_q    <= '0;
      err_cause_q <= CAUSE_MISS;
    end else begin
      if (accept) begin
        addr_min_q <= base[AV-1:0];
        addr_max_q <= sum[AV-1:0];
        wrap_q     <= sum[AV];
        id_q       <= req_id_i;
        rw_q       <= req_rw_i;
      end
      if (capture) begin
        if (fwd_hit) begin
          fwd_valid_q <= 1'b1;
          fwd_addr_q  <= lookup_out_addr_i;
          fwd_id_q    <= id_q;
          fwd_coh_q   <= lookup_coherent_i;
        end else begin
          err_valid_q <= 1'b1;
          err_id_q    <= id_q;
          err_cause_q <= cause;
        end
      end
      if (done) begin
        fwd_valid_q <= 1'b0;
        err_valid_q <= 1'b0;
      end
    end
  end

  assign push    = capture & ~fwd_hit;
  assign pop     = miss_ready_i & ~fifo_empty;
  assign ovf_set = push & fifo_full & ~pop;

  // Set wins over a same-cycle clear
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ovf_q <= 1'b0;
    end else if (ovf_set) begin
      ovf_q <= 1'b1;
    end else if (miss_overflow_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  rab_miss_fifo #(
    .WIDTH (EW),
    .DEPTH (MISS_FIFO_DEPTH)
  ) u_miss_fifo (
    .clk   (Clk_CI),
    .rst_n (Rst_RBI),
    .push  (push),
    .wdata ({addr_min_q, id_q, rw_q}),
    .pop   (miss_ready_i),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign lookup_rw_o       = rw_q;
  assign lookup_addr_min_o = addr_min_q;
  assign lookup_addr_max_o = addr_max_q;

  assign fwd_valid_o    = fwd_valid_q;
  assign fwd_addr_o     = fwd_addr_q;
  assign fwd_id_o       = fwd_id_q;
  assign fwd_coherent_o = fwd_coh_q;

  assign err_valid_o = err_valid_q;
  assign err_id_o    = err_id_q;
  assign err_cause_o = err_cause_q;

  assign miss_valid_o    = ~fifo_empty;
  assign miss_addr_o     = fifo_rdata[EW-1 -: AV];
  assign miss_id_o       = fifo_rdata[ID_WIDTH:1];
  assign miss_rw_o       = fifo_rdata[0];
  assign miss_overflow_o = ovf_q;

endmodule

// File: tb/tb_rab_lookup_ctrl.sv
// Bench for rab_lookup_ctrl: transaction model plus directed vectors.
// The model is compared with the DUT on every falling edge.
module tb_rab_lookup_ctrl;

  localparam int NS = 16;
  localparam int AV = 32;
  localparam int AP = 40;
  localparam int IW = 8;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AV-1:0] req_addr_i = '0;
  logic [7:0]    req_len_i = '0;
  logic [2:0]    req_size_i = '0;
  logic [1:0]    req_burst_i = '0;
  logic [IW-1:0] req_id_i = '0;
  logic          req_rw_i = 1'b0;
  logic          lookup_rw_o;
  logic [AV-1:0] lookup_addr_min_o;
  logic [AV-1:0] lookup_addr_max_o;
  logic [NS-1:0] lookup_hit_i = '0;
  logic [NS-1:0] lookup_prot_i = '0;
  logic          lookup_multi_hit_i = 1'b0;
  logic [AP-1:0] lookup_out_addr_i = '0;
  logic          lookup_coherent_i = 1'b0;
  logic          fwd_valid_o;
  logic          fwd_ready_i = 1'b1;
  logic [AP-1:0] fwd_addr_o;
  logic [IW-1:0] fwd_id_o;
  logic          fwd_coherent_o;
  logic          err_valid_o;
  logic          err_ready_i = 1'b1;
  logic [IW-1:0] err_id_o;
  logic [1:0]    err_cause_o;
  logic          miss_valid_o;
  logic          miss_ready_i = 1'b0;
  logic [AV-1:0] miss_addr_o;
  logic [IW-1:0] miss_id_o;
  logic          miss_rw_o;
  logic          miss_overflow_o;
  logic          miss_overflow_clr_i = 1'b0;

  always #5 clk = ~clk;

  rab_lookup_ctrl #(
    .N_SLICES        (NS),
    .ADDR_WIDTH_VIRT (AV),
    .ADDR_WIDTH_PHYS (AP),
    .ID_WIDTH        (IW),
    .MISS_FIFO_DEPTH (DEPTH)
  ) dut (
    .Clk_CI              (clk),
    .Rst_RBI             (rst_n),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_addr_i          (req_addr_i),
    .req_len_i           (req_len_i),
    .req_size_i          (req_size_i),
    .req_burst_i         (req_burst_i),
    .req_id_i            (req_id_i),
    .req_rw_i            (req_rw_i),
    .lookup_rw_o         (lookup_rw_o),
    .lookup_addr_min_o   (lookup_addr_min_o),
    .lookup_addr_max_o   (lookup_addr_max_o),
    .lookup_hit_i        (lookup_hit_i),
    .lookup_prot_i       (lookup_prot_i),
    .lookup_multi_hit_i  (lookup_multi_hit_i),
    .lookup_out_addr_i   (lookup_out_addr_i),
    .lookup_coherent_i   (lookup_coherent_i),
    .fwd_valid_o         (fwd_valid_o),
    .fwd_ready_i         (fwd_ready_i),
    .fwd_addr_o          (fwd_addr_o),
    .fwd_id_o            (fwd_id_o),
    .fwd_coherent_o      (fwd_coherent_o),
    .err_valid_o         (err_valid_o),
    .err_ready_i         (err_ready_i),
    .err_id_o            (err_id_o),
    .err_cause_o         (err_cause_o),
    .miss_valid_o        (miss_valid_o),
    .miss_ready_i        (miss_ready_i),
    .miss_addr_o         (miss_addr_o),
    .miss_id_o           (miss_id_o),
    .miss_rw_o           (miss_rw_o),
    .miss_overflow_o     (miss_overflow_o),
    .miss_overflow_clr_i (miss_overflow_clr_i)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Transaction model: phase 0 idle, 1 lookup, 2 response
  typedef struct {
    logic [AV-1:0] a;
    logic [IW-1:0] id;
    logic          rw;
  } ent_t;

  ent_t          mq[$];
  int            ph = 0;
  logic [63:0]   by, mn, mx;
  logic [AV-1:0] m_min = '0;
  logic [AV-1:0] m_max = '0;
  logic          m_wrap = 1'b0;
  logic          m_rw = 1'b0;
  logic [IW-1:0] m_id = '0;
  logic          m_fv = 1'b0;
  logic          m_ev = 1'b0;
  logic [AP-1:0] m_faddr = '0;
  logic [IW-1:0] m_fid = '0;
  logic          m_fcoh = 1'b0;
  logic [IW-1:0] m_eid = '0;
  logic [1:0]    m_cause = '0;
  logic          m_ovf = 1'b0;
  logic          m_fault;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph = 0;
      m_fv = 1'b0;
      m_ev = 1'b0;
      m_ovf = 1'b0;
      m_min = '0;
      m_max = '0;
      m_rw = 1'b0;
      mq.delete();
    end else begin
      if (miss_ready_i && mq.size() > 0) void'(mq.pop_front());
      if (miss_overflow_clr_i) m_ovf = 1'b0;
      case (ph)
        0: if (req_valid_i) begin
          if (req_burst_i == 2'b00) by = 64'd1 << req_size_i;
          else by = (64'(req_len_i) + 64'd1) << req_size_i;
          mn = 64'(req_addr_i);
          if (req_burst_i == 2'b10) mn = mn & ~(by - 64'd1);
          mx = mn + by - 64'd1;
          m_min = mn[AV-1:0];
          m_max = mx[AV-1:0];
          m_wrap = (mx > 64'hFFFF_FFFF);
          m_id = req_id_i;
          m_rw = req_rw_i;
          ph = 1;
        end
        1: begin
          m_fault = 1'b1;
          if (m_wrap) m_cause = 2'b11;
          else if (lookup_multi_hit_i) m_cause = 2'b10;
          else if (lookup_hit_i != 0) m_fault = 1'b0;
          else if (lookup_prot_i != 0) m_cause = 2'b01;
          else m_cause = 2'b00;
          if (!m_fault) begin
            m_fv = 1'b1;
            m_faddr = lookup_out_addr_i;
            m_fid = m_id;
            m_fcoh = lookup_coherent_i;
          end else begin
            m_ev = 1'b1;
            m_eid = m_id;
            if (mq.size() < DEPTH) mq.push_back('{m_min, m_id, m_rw});
            else m_ovf = 1'b1;
          end
          ph = 2;
        end
        default: begin
          if ((m_fv && fwd_ready_i) || (m_ev && err_ready_i)) begin
            m_fv = 1'b0;
            m_ev = 1'b0;
            ph = 0;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    chk("req_ready", req_ready_o, rst_n && ph == 0);
    chk("fwd_valid", fwd_valid_o, m_fv);
    chk("err_valid", err_valid_o, m_ev);
    chk("lk_min", lookup_addr_min_o, m_min);
    chk("lk_max", lookup_addr_max_o, m_max);
    chk("lk_rw", lookup_rw_o, m_rw);
    if (m_fv) begin
      chk("fwd_addr", fwd_addr_o, m_faddr);
      chk("fwd_id", fwd_id_o, m_fid);
      chk("fwd_coh", fwd_coherent_o, m_fcoh);
    end
    if (m_ev) begin
      chk("err_id", err_id_o, m_eid);
      chk("err_cause", err_cause_o, m_cause);
    end
    chk("miss_valid", miss_valid_o, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("miss_addr", miss_addr_o, mq[0].a);
      chk("miss_id", miss_id_o, mq[0].id);
      chk("miss_rw", miss_rw_o, mq[0].rw);
    end
    chk("overflow", miss_overflow_o, m_ovf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setreq(
    input logic [AV-1:0] a, input logic [7:0] len,
    input logic [2:0] sz, input logic [1:0] bu,
    input logic [IW-1:0] id, input logic rw,
    input logic [NS-1:0] hit, input logic [NS-1:0] prot,
    input logic mh, input logic [AP-1:0] oa
  );
    req_addr_i = a;
    req_len_i = len;
    req_size_i = sz;
    req_burst_i = bu;
    req_id_i = id;
    req_rw_i = rw;
    lookup_hit_i = hit;
    lookup_prot_i = prot;
    lookup_multi_hit_i = mh;
    lookup_out_addr_i = oa;
    lookup_coherent_i = oa[0] ^ oa[12];
  endtask

  task automatic accept();
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!req_ready_o && n < 50) begin
      step();
      n++;
    end
    chk("idle_timeout", req_ready_o, 1'b1);
  endtask

  task automatic drain();
    miss_ready_i = 1'b1;
    repeat (DEPTH) step();
    miss_ready_i = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) step();
    chk("rst_ready", req_ready_o, 1'b0);
    chk("rst_fwd_v", fwd_valid_o, 1'b0);
    chk("rst_err_v", err_valid_o, 1'b0);
    chk("rst_miss_v", miss_valid_o, 1'b0);
    chk("rst_ovf", miss_overflow_o, 1'b0);
    chk("rst_lk_max", lookup_addr_max_o, 32'h0);
    rst_n = 1'b1;
    step();

    // 1: INCR hit, forward
    setreq(32'h1000_0000, 8'd3, 3'd2, 2'b01, 8'h11, 1'b0,
           16'h0001, 16'h0, 1'b0, 40'h80_2000_0000);
    accept();
    chk("t1_min", lookup_addr_min_o, 32'h1000_0000);
    chk("t1_max", lookup_addr_max_o, 32'h1000_000F);
    step();
    chk("t1_fwd_v", fwd_valid_o, 1'b1);
    chk("t1_fwd_addr", fwd_addr_o, 40'h80_2000_0000);
    chk("t1_no_push", miss_valid_o, 1'b0);
    wait_idle();

    // 2: plain miss, then protection fault
    setreq(32'h1000_0000, 8'd3, 3'd2, 2'b01, 8'h22, 1'b1,
           16'h0, 16'h0, 1'b0, 40'h0);
    accept();
    step();
    chk("t2_cause", err_cause_o, 2'b00);
    chk("t2_miss_addr", miss_addr_o, 32'h1000_0000);
    chk("t2_miss_id", miss_id_o, 8'h22);
    chk("t2_miss_rw", miss_rw_o, 1'b1);
    wait_idle();
    drain();
    setreq(32'h1000_0000, 8'd3, 3'd2, 2'b01, 8'h33, 1'b0,
           16'h0, 16'h0008, 1'b0, 40'h0);
    accept();
    step();
    chk("t2_prot", err_cause_o, 2'b01);
    wait_idle();
    drain();

    // 3: address overflow beats a hit; multi-hit beats a hit
    setreq(32'hFFFF_FFF0, 8'd7, 3'd2, 2'b01, 8'h44, 1'b0,
           16'h0001, 16'h0, 1'b0, 40'h55_0000_0000);
    accept();
    step();
    chk("t3_wrap", err_cause_o, 2'b11);
    chk("t3_no_fwd", fwd_valid_o, 1'b0);
    wait_idle();
    setreq(32'h0000_2000, 8'd0, 3'd0, 2'b01, 8'h45, 1'b1,
           16'h0003, 16'h0, 1'b1, 40'h0);
    accept();
    step();
    chk("t3_multi", err_cause_o, 2'b10);
    wait_idle();
    drain();

    // window shapes: WRAP, FIXED, reserved burst as INCR
    setreq(32'h1000_0034, 8'd3, 3'd2, 2'b10, 8'h46, 1'b0,
           16'h8000, 16'h0, 1'b0, 40'h01_0000_1000);
    accept();
    chk("wrap_min", lookup_addr_min_o, 32'h1000_0030);
    chk("wrap_max", lookup_addr_max_o, 32'h1000_003F);
    wait_idle();
    setreq(32'h2000_0001, 8'd9, 3'd3, 2'b00, 8'h47, 1'b1,
           16'h0010, 16'h0, 1'b0, 40'h02_0000_0000);
    accept();
    chk("fixed_max", lookup_addr_max_o, 32'h2000_0008);
    wait_idle();
    setreq(32'h0000_0100, 8'd1, 3'd0, 2'b11, 8'h48, 1'b0,
           16'h0100, 16'h0, 1'b0, 40'h03_0000_0000);
    accept();
    chk("rsv_max", lookup_addr_max_o, 32'h0000_0101);
    wait_idle();

    // 4: fill the miss log, overflow, ordered drain, clear
    for (int i = 0; i < 5; i++) begin
      setreq(32'h4000_0000 + 32'(i) * 32'h100, 8'd0, 3'd0,
             2'b01, 8'(8'h40 + i), 1'(i), 16'h0, 16'h0,
             1'b0, 40'h0);
      accept();
      if (i == 4) miss_overflow_clr_i = 1'b1;
      step();
      miss_overflow_clr_i = 1'b0;
      if (i == 3) chk("t4_ovf_pre", miss_overflow_o, 1'b0);
      wait_idle();
    end
    chk("t4_ovf_set", miss_overflow_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t4_order", miss_addr_o,
          32'h4000_0000 + 32'(i) * 32'h100);
      miss_ready_i = 1'b1;
      step();
      miss_ready_i = 1'b0;
    end
    chk("t4_empty", miss_valid_o, 1'b0);
    chk("t4_ovf_held", miss_overflow_o, 1'b1);
    miss_overflow_clr_i = 1'b1;
    step();
    miss_overflow_clr_i = 1'b0;
    chk("t4_ovf_clr", miss_overflow_o, 1'b0);

    // full FIFO with a pop in the push cycle: no overflow
    for (int i = 0; i < 5; i++) begin
      setreq(32'h5000_0000 + 32'(i) * 32'h100, 8'd0, 3'd0,
             2'b01, 8'(8'h50 + i), 1'b0, 16'h0, 16'h0,
             1'b0, 40'h0);
      accept();
      if (i == 4) miss_ready_i = 1'b1;
      step();
      miss_ready_i = 1'b0;
      wait_idle();
    end
    chk("t4_pushpop_ovf", miss_overflow_o, 1'b0);
    chk("t4_pushpop_head", miss_addr_o, 32'h5000_0100);
    drain();

    // 5: back-pressure on the forward port
    fwd_ready_i = 1'b0;
    setreq(32'h3000_0000, 8'd1, 3'd2, 2'b01, 8'h55, 1'b0,
           16'h0004, 16'h0, 1'b0, 40'h12_3456_7000);
    accept();
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_hold_addr", fwd_addr_o, 40'h12_3456_7000);
      chk("t5_hold_rdy", req_ready_o, 1'b0);
      step();
    end
    setreq(32'h3000_1000, 8'd0, 3'd2, 2'b01, 8'h56, 1'b1,
           16'h0002, 16'h0, 1'b0, 40'hAB_0000_0000);
    req_valid_i = 1'b1;
    fwd_ready_i = 1'b1;
    step();
    chk("t5_ready_after", req_ready_o, 1'b1);
    step();
    req_valid_i = 1'b0;
    chk("t5_accepted", req_ready_o, 1'b0);
    wait_idle();

    // 6: reset during lookup
    setreq(32'h6000_0000, 8'd0, 3'd0, 2'b01, 8'h60, 1'b1,
           16'h0, 16'h0, 1'b0, 40'h0);
    accept();
    wait_idle();
    chk("t6_pre_miss", miss_valid_o, 1'b1);
    setreq(32'h6000_1000, 8'd0, 3'd0, 2'b01, 8'h61, 1'b0,
           16'h0001, 16'h0, 1'b0, 40'h06_0000_0000);
    accept();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_fwd_v", fwd_valid_o, 1'b0);
    chk("t6_err_v", err_valid_o, 1'b0);
    chk("t6_miss_v", miss_valid_o, 1'b0);
    chk("t6_ready", req_ready_o, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("t6_ready_rel", req_ready_o, 1'b1);
    accept();
    step();
    chk("t6_again", fwd_valid_o, 1'b1);
    wait_idle();

    repeat (2) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
